// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer: line-granular write buffer between the CPU physical-memory
// port and physical memory. Dirty-line writes are absorbed in one handshake,
// reads that hit a buffered line are served locally, and entries drain to
// memory in FIFO order whenever the upstream port is idle.
//
// Optional feature macro: WBUF_FLUSH_EN (adds flush / flush_done).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   mem_address/read/write upstream request (held until mem_resp)
//   mem_wdata, mem_rdata   upstream write line / registered read line
//   mem_resp               one-cycle upstream completion pulse
//   pmem_address/read/write/wdata/rdata/resp  downstream memory port
//   wbuf_count             number of occupied entries
//   flush, flush_done      (WBUF_FLUSH_EN only) drain-all request / done pulse
module pmem_write_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            mem_address,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [BLOCK_W-1:0]           mem_wdata,
    output logic [BLOCK_W-1:0]           mem_rdata,
    output logic                         mem_resp,
    output logic [ADDR_W-1:0]            pmem_address,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [BLOCK_W-1:0]           pmem_wdata,
    input  logic [BLOCK_W-1:0]           pmem_rdata,
    input  logic                         pmem_resp,
`ifdef WBUF_FLUSH_EN
    input  logic                         flush,
    output logic                         flush_done,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   wbuf_count
);

    localparam int unsigned OFF_W = $clog2(BLOCK_W / 8);
    localparam int unsigned TAG_W = ADDR_W - OFF_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RESP, READ_MEM, DRAIN} state_t;

    state_t               state;
    logic [TAG_W-1:0]     tags   [DEPTH];
    logic [BLOCK_W-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
`ifdef WBUF_FLUSH_EN
    logic                 flush_mode;
`endif

    logic [TAG_W-1:0]     req_tag;
    logic                 hit;
    logic [PTR_W-1:0]     hit_idx;
    logic                 full;
    logic                 unused_offset;

    assign req_tag       = mem_address[ADDR_W-1:OFF_W];
    assign full          = (wbuf_count == CNT_W'(DEPTH));
    assign unused_offset = ^mem_address[OFF_W-1:0];

    // Parallel tag compare; coalescing guarantees at most one valid match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tags[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // Control FSM, FIFO storage and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid        <= '0;
            head         <= '0;
            tail         <= '0;
            wbuf_count   <= '0;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tags[i]   <= '0;
                data_q[i] <= '0;
            end
`ifdef WBUF_FLUSH_EN
            flush_mode   <= 1'b0;
            flush_done   <= 1'b0;
`endif
        end else begin
            mem_resp <= 1'b0;
`ifdef WBUF_FLUSH_EN
            flush_done <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef WBUF_FLUSH_EN
                    // Flush mode ignores upstream until the buffer is empty.
                    if (flush_mode) begin
                        pmem_write   <= 1'b1;
                        pmem_address <= {tags[head], {OFF_W{1'b0}}};
                        pmem_wdata   <= data_q[head];
                        state        <= DRAIN;
                    end else
`endif
                    if (mem_read) begin
                        if (hit) begin
                            mem_rdata <= data_q[hit_idx];
                            mem_resp  <= 1'b1;
                            state     <= RESP;
                        end else begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, {OFF_W{1'b0}}};
                            state        <= READ_MEM;
                        end
                    end else if (mem_write) begin
                        if (hit) begin
                            data_q[hit_idx] <= mem_wdata;
                            mem_resp        <= 1'b1;
                            state           <= RESP;
                        end else if (!full) begin
                            tags[tail]   <= req_tag;
                            data_q[tail] <= mem_wdata;
                            valid[tail]  <= 1'b1;
                            tail         <= tail + PTR_W'(1);
                            wbuf_count   <= wbuf_count + CNT_W'(1);
                            mem_resp     <= 1'b1;
                            state        <= RESP;
                        end else begin
                            // Full: free the head entry; the write retries from IDLE.
                            pmem_write   <= 1'b1;
                            pmem_address <= {tags[head], {OFF_W{1'b0}}};
                            pmem_wdata   <= data_q[head];
                            state        <= DRAIN;
                        end
                    end
`ifdef WBUF_FLUSH_EN
                    else if (flush) begin
                        if (wbuf_count == '0) begin
                            flush_done <= 1'b1;
                        end else begin
                            flush_mode   <= 1'b1;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tags[head], {OFF_W{1'b0}}};
                            pmem_wdata   <= data_q[head];
                            state        <= DRAIN;
                        end
                    end
`endif
                    else if (wbuf_count != '0) begin
                        pmem_write   <= 1'b1;
                        pmem_address <= {tags[head], {OFF_W{1'b0}}};
                        pmem_wdata   <= data_q[head];
                        state        <= DRAIN;
                    end
                end

                READ_MEM: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        mem_rdata <= pmem_rdata;
                        mem_resp  <= 1'b1;
                        state     <= RESP;
                    end
                end

                DRAIN: begin
                    if (pmem_resp) begin
                        pmem_write  <= 1'b0;
                        valid[head] <= 1'b0;
                        head        <= head + PTR_W'(1);
                        wbuf_count  <= wbuf_count - CNT_W'(1);
`ifdef WBUF_FLUSH_EN
                        if (flush_mode && (wbuf_count == CNT_W'(1))) begin
                            flush_mode <= 1'b0;
                            flush_done <= 1'b1;
                        end
`endif
                        state       <= IDLE;
                    end
                end

                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_write_buffer.sv
module tb_pmem_write_buffer;

    logic          clk;
    logic          rst_n;
    logic [15:0]   mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_resp;
    logic [15:0]   pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [127:0]  pmem_wdata;
    logic [127:0]  pmem_rdata;
    logic          pmem_resp;
    logic [2:0]    wbuf_count;
`ifdef WBUF_FLUSH_EN
    logic          flush;
    logic          flush_done;
    initial flush = 1'b0;
`endif

    pmem_write_buffer #(.DEPTH(4), .ADDR_W(16), .BLOCK_W(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
`ifdef WBUF_FLUSH_EN
        .flush        (flush),
        .flush_done   (flush_done),
`endif
        .wbuf_count   (wbuf_count)
    );

    typedef struct packed {
        logic         chk;
        logic [127:0] data;
    } resp_t;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } pm_t;

    resp_t exp_resp[$];
    pm_t   exp_pm[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pm_lat   = 1;
    int last_hi  = 0;

    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DE = {4{32'hEEEE_0005}};
    localparam logic [127:0] DF = {4{32'hFFFF_0006}};
    localparam logic [127:0] DG = {4{32'h1234_0007}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one upstream request at a negedge and wait for mem_resp.
    task automatic do_req(input logic rd, input logic [15:0] a, input logic [127:0] d,
                          input bit keep, output int lat_o);
        bit got;
        got = 1'b0;
        lat_o = 0;
        mem_address = a;
        mem_read    = rd;
        mem_write   = ~rd;
        mem_wdata   = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            lat_o++;
            if (mem_resp) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: addr %h no mem_resp within 300 cycles", a);
        end
        if (!keep) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (wbuf_count == 3'd0 && !pmem_write && !pmem_read) break;
        end
        check("wait_empty_count", 128'(wbuf_count), 128'(0));
    endtask

    // Upstream response monitor: pops the scoreboard on every mem_resp.
    resp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && mem_resp) begin
            if (exp_resp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mem_resp: rdata %h", mem_rdata);
            end else begin
                mon_e = exp_resp.pop_front();
                if (mon_e.chk) check("mem_rdata", mem_rdata, mon_e.data);
            end
        end
    end

    // Physical memory model: checks each transaction against the scoreboard.
    pm_t pm_e;
    int  hi;
    bit  aborted;
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (pmem_read || pmem_write)) begin
                check("pmem_rd_wr_exclusive", 128'(pmem_read & pmem_write), 128'(0));
                if (exp_pm.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pmem: rd %0b wr %0b addr %h", pmem_read, pmem_write, pmem_address);
                    pm_e = '0;
                end else begin
                    pm_e = exp_pm.pop_front();
                    check("pmem_is_write", 128'(pmem_write), 128'(pm_e.wr));
                    check("pmem_address", 128'(pmem_address), 128'(pm_e.addr));
                    if (pm_e.wr) check("pmem_wdata", pmem_wdata, pm_e.data);
                end
                hi = 1;
                aborted = 1'b0;
                while (hi < pm_lat) begin
                    @(negedge clk);
                    if (!rst_n || !(pmem_read || pmem_write)) begin
                        aborted = 1'b1;
                        break;
                    end
                    hi++;
                end
                if (!aborted) begin
                    pmem_rdata = pm_e.data;
                    pmem_resp  = 1'b1;
                    last_hi    = hi;
                    @(negedge clk);
                    pmem_resp  = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    int lat;

    initial begin
        rst_n       = 1'b0;
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        #12;
        check("rst_mem_resp",     128'(mem_resp),     128'(0));
        check("rst_mem_rdata",    mem_rdata,          128'(0));
        check("rst_pmem_read",    128'(pmem_read),    128'(0));
        check("rst_pmem_write",   128'(pmem_write),   128'(0));
        check("rst_pmem_address", 128'(pmem_address), 128'(0));
        check("rst_pmem_wdata",   pmem_wdata,         128'(0));
        check("rst_wbuf_count",   128'(wbuf_count),   128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read-hit on the same line served from the buffer.
        exp_pm.push_back('{wr: 1'b1, addr: 16'h1230, data: DA});
        exp_resp.push_back('{chk: 1'b0, data: '0});
        do_req(1'b0, 16'h1230, DA, 1'b1, lat);
        exp_resp.push_back('{chk: 1'b1, data: DA});
        do_req(1'b1, 16'h1238, '0, 1'b0, lat);
        check("hit_count", 128'(wbuf_count), 128'(1));
        wait_empty();

        // Coalescing two writes to one line.
        exp_pm.push_back('{wr: 1'b1, addr: 16'h0040, data: DB});
        exp_resp.push_back('{chk: 1'b0, data: '0});
        do_req(1'b0, 16'h0040, DA, 1'b1, lat);
        exp_resp.push_back('{chk: 1'b0, data: '0});
        do_req(1'b0, 16'h004F, DB, 1'b0, lat);
        check("coalesce_count", 128'(wbuf_count), 128'(1));
        wait_empty();

        // Fill to DEPTH, then a fifth write forces the head drain first.
        exp_pm.push_back('{wr: 1'b1, addr: 16'h0000, data: 128'h10});
        exp_pm.push_back('{wr: 1'b1, addr: 16'h0010, data: 128'h11});
        exp_pm.push_back('{wr: 1'b1, addr: 16'h0020, data: 128'h12});
        exp_pm.push_back('{wr: 1'b1, addr: 16'h0030, data: 128'h13});
        exp_pm.push_back('{wr: 1'b1, addr: 16'h0040, data: 128'h14});
        for (int i = 0; i < 4; i++) begin
            exp_resp.push_back('{chk: 1'b0, data: '0});
            do_req(1'b0, 16'(i * 16), 128'(16 + i), 1'b1, lat);
        end
        check("full_count", 128'(wbuf_count), 128'(4));
        exp_resp.push_back('{chk: 1'b0, data: '0});
        do_req(1'b0, 16'h0040, 128'h14, 1'b0, lat);
        check("after_full_count", 128'(wbuf_count), 128'(4));
        wait_empty();

        // Read miss with 5-cycle memory latency.
        pm_lat = 5;
        exp_pm.push_back('{wr: 1'b0, addr: 16'h2000, data: DC});
        exp_resp.push_back('{chk: 1'b1, data: DC});
        do_req(1'b1, 16'h2000, '0, 1'b0, lat);
        check("miss_pmem_read_cycles", 128'(last_hi), 128'(5));
        check("miss_latency", 128'(lat), 128'(6));

        // Read arriving mid-drain waits for the drain to complete.
        pm_lat = 4;
        exp_pm.push_back('{wr: 1'b1, addr: 16'h3000, data: DE});
        exp_pm.push_back('{wr: 1'b0, addr: 16'h5000, data: DF});
        exp_resp.push_back('{chk: 1'b0, data: '0});
        do_req(1'b0, 16'h3000, DE, 1'b0, lat);
        repeat (2) @(negedge clk);
        check("mid_drain_active", 128'(pmem_write), 128'(1));
        exp_resp.push_back('{chk: 1'b1, data: DF});
        do_req(1'b1, 16'h5000, '0, 1'b0, lat);
        check("mid_drain_count", 128'(wbuf_count), 128'(0));

        // Reset during a drain.
        pm_lat = 30;
        exp_pm.push_back('{wr: 1'b1, addr: 16'h6000, data: DG});
        exp_resp.push_back('{chk: 1'b0, data: '0});
        do_req(1'b0, 16'h6000, DG, 1'b0, lat);
        repeat (3) @(negedge clk);
        check("pre_reset_drain", 128'(pmem_write), 128'(1));
        rst_n = 1'b0;
        #1;
        check("reset_pmem_write", 128'(pmem_write), 128'(0));
        check("reset_count", 128'(wbuf_count), 128'(0));
        check("reset_pmem_address", 128'(pmem_address), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pm_lat = 1;
        repeat (10) @(negedge clk);
        check("post_reset_pmem_write", 128'(pmem_write), 128'(0));
        check("post_reset_pmem_read", 128'(pmem_read), 128'(0));
        check("post_reset_count", 128'(wbuf_count), 128'(0));

        check("resp_queue_empty", 128'(exp_resp.size()), 128'(0));
        check("pmem_queue_empty", 128'(exp_pm.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
